// File: rtl/rs232_tx.sv
// rtl/rs232_tx.sv - RS232 serial transmit engine with one-word holding buffer
module rs232_tx #(
    parameter int DATA_W     = 8,
    parameter int PARITY_EN  = 1,
    parameter int PARITY_ODD = 1,
    parameter int STOP_BITS  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clk_rs232_en,
    input  logic              send_word,
    input  logic [DATA_W-1:0] data_in,
    output logic              word_ready,
    output logic              busy,
    output logic              tx_done,
    output logic              tx
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(DATA_W - 1);
    localparam logic STOP_LAST = 1'(STOP_BITS - 1);
    localparam logic PAR_INV   = 1'(PARITY_ODD);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    logic [2:0]        state;
    logic [DATA_W-1:0] buf_data;
    logic              buf_full;
    logic [DATA_W-1:0] frame_word;
    logic              parity_bit;
    logic [CNT_W-1:0]  bit_cnt;
    logic              stop_cnt;
    logic              accept;
    logic              frame_end;
    logic              load_frame;

    // The holding buffer is the only source of backpressure, so ready is just "buffer empty".
    assign word_ready = ~buf_full;
    assign accept     = send_word & ~buf_full;

    // Last stop period finishing on this strobe.
    assign frame_end  = clk_rs232_en & (state == S_STOP) & (stop_cnt == STOP_LAST);

    // A frame starts from IDLE or straight out of the last stop bit, whichever sees a full buffer on a strobe.
    assign load_frame = clk_rs232_en & buf_full & ((state == S_IDLE) | frame_end);

    // Holding buffer: fills on handshake, empties when its word moves into the frame register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            buf_full <= 1'b0;
            buf_data <= '0;
        end else if (load_frame) begin
            buf_full <= 1'b0;
        end else if (accept) begin
            buf_full <= 1'b1;
            buf_data <= data_in;
        end
    end

    // Frame sequencer: every state change and every tx update happens on a baud strobe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            tx         <= 1'b1;
            busy       <= 1'b0;
            tx_done    <= 1'b0;
            frame_word <= '0;
            parity_bit <= 1'b0;
            bit_cnt    <= '0;
            stop_cnt   <= 1'b0;
        end else begin
            tx_done <= frame_end;
            if (load_frame) begin
                // Parity is taken from the buffered word so later data_in changes cannot leak in.
                state      <= S_START;
                tx         <= 1'b0;
                busy       <= 1'b1;
                frame_word <= buf_data;
                parity_bit <= (^buf_data) ^ PAR_INV;
            end else if (clk_rs232_en) begin
                case (state)
                    S_IDLE: begin
                        tx <= 1'b1;
                    end
                    S_START: begin
                        state   <= S_DATA;
                        bit_cnt <= BIT_LAST;
                        tx      <= frame_word[BIT_LAST];
                    end
                    S_DATA: begin
                        if (bit_cnt == '0) begin
                            if (PARITY_EN != 0) begin
                                state <= S_PARITY;
                                tx    <= parity_bit;
                            end else begin
                                state    <= S_STOP;
                                stop_cnt <= 1'b0;
                                tx       <= 1'b1;
                            end
                        end else begin
                            bit_cnt <= bit_cnt - 1'b1;
                            tx      <= frame_word[bit_cnt - 1'b1];
                        end
                    end
                    S_PARITY: begin
                        state    <= S_STOP;
                        stop_cnt <= 1'b0;
                        tx       <= 1'b1;
                    end
                    S_STOP: begin
                        if (stop_cnt == STOP_LAST) begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                            tx    <= 1'b1;
                        end else begin
                            stop_cnt <= stop_cnt + 1'b1;
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                        tx    <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule
